// File: rtl/axi4_lite_register_bank.sv
// -----------------------------------------------------------------------------
// axi4_lite_register_bank
//
// AXI4-lite slave register file sitting between the interconnect and a
// peripheral's control/status logic. It supports any register count from 1 to
// 256, byte-strobed writes, and per-register access modes:
//   - read-write (RW)
//   - read-only (RO): the value comes from i_reg_in
//   - write-1-to-clear (W1C): bits are set by hardware through i_hw_set
// If a register is marked both RO and W1C, RO takes priority.
//
// Handshakes go through a small write FSM and a small read FSM. There are no
// channel FIFOs.
//
// Optional feature macro: AXI4_LITE_REG_BANK_SLVERR_EN
//   defined   : out-of-range accesses respond SLVERR (2'b10)
//   undefined : every access responds OKAY (2'b00)
//
// Parameters:
//   N_REGS   register count (1..256)
//   DW       data width (32 or 64)
//   AW       byte address width
//   RO_MASK  bit i set -> register i is read-only
//   W1C_MASK bit i set -> register i is write-1-to-clear
//   RST_VAL  reset value of every RW/W1C register
//
// Ports:
//   i_aclk, i_aresetn                    clock, async active-low reset
//   i_awvalid/o_awready, i_awaddr        write address channel
//   i_wvalid/o_wready, i_wdata, i_wstrb  write data channel
//   o_bvalid/i_bready, o_bresp           write response channel
//   i_arvalid/o_arready, i_araddr        read address channel
//   o_rvalid/i_rready, o_rdata, o_rresp  read data channel
//   o_reg_out   register contents, register i at [i*DW +: DW]
//   i_reg_in    hardware values for RO registers
//   i_hw_set    per-bit set requests for W1C registers
//   o_wr_pulse  one-cycle strobe when register i is committed
//   o_rd_pulse  one-cycle strobe when register i is read (AR handshake)
// -----------------------------------------------------------------------------
module axi4_lite_register_bank #(
   parameter int unsigned        N_REGS   = 16,
   parameter int unsigned        DW       = 32,
   parameter int unsigned        AW       = 12,
   parameter logic [N_REGS-1:0]  RO_MASK  = '0,
   parameter logic [N_REGS-1:0]  W1C_MASK = '0,
   parameter logic [DW-1:0]      RST_VAL  = '0
) (
   input  logic                 i_aclk,
   input  logic                 i_aresetn,
   // write address
   input  logic                 i_awvalid,
   output logic                 o_awready,
   input  logic [AW-1:0]        i_awaddr,
   // write data
   input  logic                 i_wvalid,
   output logic                 o_wready,
   input  logic [DW-1:0]        i_wdata,
   input  logic [DW/8-1:0]      i_wstrb,
   // write response
   output logic                 o_bvalid,
   input  logic                 i_bready,
   output logic [1:0]           o_bresp,
   // read address
   input  logic                 i_arvalid,
   output logic                 o_arready,
   input  logic [AW-1:0]        i_araddr,
   // read data
   output logic                 o_rvalid,
   input  logic                 i_rready,
   output logic [DW-1:0]        o_rdata,
   output logic [1:0]           o_rresp,
   // register side
   output logic [N_REGS*DW-1:0] o_reg_out,
   input  logic [N_REGS*DW-1:0] i_reg_in,
   input  logic [N_REGS*DW-1:0] i_hw_set,
   output logic [N_REGS-1:0]    o_wr_pulse,
   output logic [N_REGS-1:0]    o_rd_pulse
);

   localparam int unsigned SW = DW / 8;
   localparam int unsigned LB = $clog2(SW);
   localparam int unsigned IW = AW - LB;

   localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXI4_LITE_REG_BANK_SLVERR_EN
   localparam logic [1:0] RESP_OOR  = 2'b10;
`else
   localparam logic [1:0] RESP_OOR  = 2'b00;
`endif

   // Write FSM encoding
   localparam logic [1:0] W_IDLE   = 2'd0;
   localparam logic [1:0] W_COMMIT = 2'd1;
   localparam logic [1:0] W_RESP   = 2'd2;

   // Read FSM encoding
   localparam logic R_IDLE = 1'b0;
   localparam logic R_DATA = 1'b1;

   // ---------------------------------------------------------------------------
   // Write path
   // ---------------------------------------------------------------------------
   logic [1:0]        r_wstate;
   logic              r_aw_held;
   logic              r_w_held;
   logic [AW-1:0]     r_awaddr;
   logic [DW-1:0]     r_wdata;
   logic [SW-1:0]     r_wstrb;
   logic [1:0]        r_bresp;

   logic              w_aw_hs;
   logic              w_w_hs;
   logic              w_commit;
   logic [IW-1:0]     w_widx;
   logic [N_REGS-1:0] w_wsel;
   logic              w_wrange;
   logic [DW-1:0]     w_bmask;

   assign o_awready = (r_wstate == W_IDLE) & ~r_aw_held;
   assign o_wready  = (r_wstate == W_IDLE) & ~r_w_held;
   assign o_bvalid  = (r_wstate == W_RESP);
   assign o_bresp   = r_bresp;

   assign w_aw_hs   = i_awvalid & o_awready;
   assign w_w_hs    = i_wvalid & o_wready;
   assign w_commit  = (r_wstate == W_COMMIT);
   assign w_widx    = r_awaddr[AW-1:LB];

   // One-hot decode of the held write address; all-zero when out of range
   always_comb begin
      w_wsel = '0;
      for (int i = 0; i < N_REGS; i++) begin
         w_wsel[i] = (w_widx == IW'(i));
      end
   end
   assign w_wrange = |w_wsel;

   always_comb begin
      w_bmask = '0;
      for (int b = 0; b < SW; b++) begin
         w_bmask[b*8 +: 8] = {8{r_wstrb[b]}};
      end
   end

   assign o_wr_pulse = w_commit ? w_wsel : '0;

   always_ff @(posedge i_aclk or negedge i_aresetn) begin
      if (!i_aresetn) begin
         r_wstate  <= W_IDLE;
         r_aw_held <= 1'b0;
         r_w_held  <= 1'b0;
         r_awaddr  <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         r_bresp   <= RESP_OKAY;
      end else begin
         case (r_wstate)
            W_IDLE: begin
               if (w_aw_hs) begin
                  r_aw_held <= 1'b1;
                  r_awaddr  <= i_awaddr;
               end
               if (w_w_hs) begin
                  r_w_held <= 1'b1;
                  r_wdata  <= i_wdata;
                  r_wstrb  <= i_wstrb;
               end
               // Counting a same-cycle handshake as held saves a cycle of latency
               if ((r_aw_held | w_aw_hs) && (r_w_held | w_w_hs)) begin
                  r_wstate <= W_COMMIT;
               end
            end
            W_COMMIT: begin
               r_bresp  <= w_wrange ? RESP_OKAY : RESP_OOR;
               r_wstate <= W_RESP;
            end
            W_RESP: begin
               if (i_bready) begin
                  r_aw_held <= 1'b0;
                  r_w_held  <= 1'b0;
                  r_wstate  <= W_IDLE;
               end
            end
            default: r_wstate <= W_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Register storage, one slice per register according to its access mode
   // ---------------------------------------------------------------------------
   for (genvar g = 0; g < N_REGS; g++) begin : g_reg
      if (RO_MASK[g]) begin : g_ro
         assign o_reg_out[g*DW +: DW] = i_reg_in[g*DW +: DW];
      end else if (W1C_MASK[g]) begin : g_w1c
         logic [DW-1:0] r_val;
         logic [DW-1:0] w_clr;

         assign w_clr = (w_commit && w_wsel[g]) ? (r_wdata & w_bmask) : '0;

         // Applying the set after the clear lets a coincident hardware set win
         always_ff @(posedge i_aclk or negedge i_aresetn) begin
            if (!i_aresetn) begin
               r_val <= RST_VAL;
            end else begin
               r_val <= (r_val & ~w_clr) | i_hw_set[g*DW +: DW];
            end
         end
         assign o_reg_out[g*DW +: DW] = r_val;
      end else begin : g_rw
         logic [DW-1:0] r_val;

         always_ff @(posedge i_aclk or negedge i_aresetn) begin
            if (!i_aresetn) begin
               r_val <= RST_VAL;
            end else if (w_commit && w_wsel[g]) begin
               r_val <= (r_val & ~w_bmask) | (r_wdata & w_bmask);
            end
         end
         assign o_reg_out[g*DW +: DW] = r_val;
      end
   end

   // ---------------------------------------------------------------------------
   // Read path
   // ---------------------------------------------------------------------------
   logic              r_rstate;
   logic [DW-1:0]     r_rdata;
   logic [1:0]        r_rresp;

   logic              w_ar_hs;
   logic [IW-1:0]     w_ridx;
   logic [N_REGS-1:0] w_rsel;
   logic              w_rrange;
   logic [DW-1:0]     w_rd_val;

   assign o_arready = (r_rstate == R_IDLE);
   assign o_rvalid  = (r_rstate == R_DATA);
   assign o_rdata   = r_rdata;
   assign o_rresp   = r_rresp;

   assign w_ar_hs = i_arvalid & o_arready;
   assign w_ridx  = i_araddr[AW-1:LB];

   always_comb begin
      w_rsel = '0;
      for (int i = 0; i < N_REGS; i++) begin
         w_rsel[i] = (w_ridx == IW'(i));
      end
   end
   assign w_rrange = |w_rsel;

   // o_reg_out already carries i_reg_in for RO slots, so one mux covers all
   // modes. An out-of-range index selects nothing and yields zero.
   always_comb begin
      w_rd_val = '0;
      for (int i = 0; i < N_REGS; i++) begin
         if (w_rsel[i]) begin
            w_rd_val = o_reg_out[i*DW +: DW];
         end
      end
   end

   assign o_rd_pulse = w_ar_hs ? w_rsel : '0;

   always_ff @(posedge i_aclk or negedge i_aresetn) begin
      if (!i_aresetn) begin
         r_rstate <= R_IDLE;
         r_rdata  <= '0;
         r_rresp  <= RESP_OKAY;
      end else begin
         case (r_rstate)
            R_IDLE: begin
               if (w_ar_hs) begin
                  r_rdata  <= w_rd_val;
                  r_rresp  <= w_rrange ? RESP_OKAY : RESP_OOR;
                  r_rstate <= R_DATA;
               end
            end
            R_DATA: begin
               if (i_rready) begin
                  r_rstate <= R_IDLE;
               end
            end
            default: r_rstate <= R_IDLE;
         endcase
      end
   end

   // Inputs that only matter for some register modes, plus ignored address bits
   logic w_unused;
   assign w_unused = ^{i_reg_in, i_hw_set, r_awaddr[LB-1:0], i_araddr[LB-1:0]};

endmodule

// File: tb/tb_axi4_lite_register_bank.sv
module tb_axi4_lite_register_bank;

   localparam int unsigned N  = 5;
   localparam int unsigned DW = 32;
   localparam int unsigned AW = 12;
   localparam logic [31:0] RV = 32'hA5A5_0000;
`ifdef AXI4_LITE_REG_BANK_SLVERR_EN
   localparam logic [1:0] OOR_RESP = 2'b10;
`else
   localparam logic [1:0] OOR_RESP = 2'b00;
`endif

   logic            clk = 1'b0;
   logic            aresetn;
   logic            awvalid, awready, wvalid, wready, bvalid, bready;
   logic            arvalid, arready, rvalid, rready;
   logic [AW-1:0]   awaddr, araddr;
   logic [DW-1:0]   wdata, rdata;
   logic [3:0]      wstrb;
   logic [1:0]      bresp, rresp;
   logic [N*DW-1:0] reg_out, reg_in, hw_set;
   logic [N-1:0]    wr_pulse, rd_pulse;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;
   int wr_cnt  = 0;
   int rd_cnt  = 0;

   always #5 clk = ~clk;

   axi4_lite_register_bank #(
      .N_REGS   (N),
      .DW       (DW),
      .AW       (AW),
      .RO_MASK  (5'b01000),
      .W1C_MASK (5'b00010),
      .RST_VAL  (RV)
   ) dut (
      .i_aclk     (clk),
      .i_aresetn  (aresetn),
      .i_awvalid  (awvalid),
      .o_awready  (awready),
      .i_awaddr   (awaddr),
      .i_wvalid   (wvalid),
      .o_wready   (wready),
      .i_wdata    (wdata),
      .i_wstrb    (wstrb),
      .o_bvalid   (bvalid),
      .i_bready   (bready),
      .o_bresp    (bresp),
      .i_arvalid  (arvalid),
      .o_arready  (arready),
      .i_araddr   (araddr),
      .o_rvalid   (rvalid),
      .i_rready   (rready),
      .o_rdata    (rdata),
      .o_rresp    (rresp),
      .o_reg_out  (reg_out),
      .i_reg_in   (reg_in),
      .i_hw_set   (hw_set),
      .o_wr_pulse (wr_pulse),
      .o_rd_pulse (rd_pulse)
   );

   always @(posedge clk) begin
      wr_cnt <= wr_cnt + $countones(wr_pulse);
      rd_cnt <= rd_cnt + $countones(rd_pulse);
   end

   task automatic chk(input string tag, input logic [N*DW-1:0] obs,
                      input logic [N*DW-1:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [1:0] resp);
      bit aw_go, w_go;
      int n;
      @(negedge clk);
      awvalid = 1'b1; awaddr = a; wvalid = 1'b1; wdata = d; wstrb = s;
      n = 0;
      while ((awvalid || wvalid) && n < 20) begin
         aw_go = awvalid && awready;
         w_go  = wvalid && wready;
         @(negedge clk);
         if (aw_go) awvalid = 1'b0;
         if (w_go)  wvalid  = 1'b0;
         n++;
      end
      awvalid = 1'b0; wvalid = 1'b0;
      bready = 1'b1;
      n = 0;
      while (!bvalid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("wr_bvalid_seen", bvalid, 1);
      resp = bresp;
      @(negedge clk);
      bready = 1'b0;
   endtask

   task automatic axi_read(input logic [AW-1:0] a, output logic [31:0] d,
                           output logic [1:0] resp);
      bit go;
      int n;
      @(negedge clk);
      arvalid = 1'b1; araddr = a; rready = 1'b1;
      n = 0;
      while (arvalid && n < 20) begin
         go = arready;
         @(negedge clk);
         if (go) arvalid = 1'b0;
         n++;
      end
      arvalid = 1'b0;
      n = 0;
      while (!rvalid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("rd_rvalid_seen", rvalid, 1);
      d = rdata;
      resp = rresp;
      @(negedge clk);
      rready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]      resp;
      logic [31:0]     d;
      logic [N*DW-1:0] exp_all;
      int              c0;

      aresetn = 1'b0;
      awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
      awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
      hw_set = '0;
      reg_in = '0;
      reg_in[96 +: 32] = RV;
      repeat (3) @(negedge clk);
      aresetn = 1'b1;
      @(negedge clk);

      // Reset state
      chk("rst_reg_out", reg_out, {5{RV}});
      chk("rst_awready", awready, 1);
      chk("rst_wready", wready, 1);
      chk("rst_arready", arready, 1);
      chk("rst_bvalid", bvalid, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_bresp", bresp, 0);
      chk("rst_rresp", rresp, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_wr_pulse", wr_pulse, 0);
      chk("rst_rd_pulse", rd_pulse, 0);

      // Clear reg2 so the strobed write below starts from zero
      axi_write(12'h008, 32'h0, 4'hF, resp);
      chk("reg2_zero", reg_out[64 +: 32], 32'h0);
      chk("reg2_zero_bresp", resp, 2'b00);

      // W handshake two cycles before AW
      @(negedge clk);
      wvalid = 1'b1; wdata = 32'h1122_3344; wstrb = 4'b0101;
      @(negedge clk);
      wvalid = 1'b0;
      chk("wfirst_wready_held", wready, 0);
      chk("wfirst_awready", awready, 1);
      chk("wfirst_bvalid_early", bvalid, 0);
      @(negedge clk);
      awvalid = 1'b1; awaddr = 12'h008;
      @(negedge clk);
      chk("wfirst_wr_pulse", wr_pulse, 5'b00100);
      chk("wfirst_reg2_pre", reg_out[64 +: 32], 32'h0);
      chk("wfirst_bvalid_commit", bvalid, 0);
      awvalid = 1'b0;
      @(negedge clk);
      chk("wfirst_reg2", reg_out[64 +: 32], 32'h0022_0044);
      chk("wfirst_bvalid", bvalid, 1);
      chk("wfirst_wr_pulse_off", wr_pulse, 5'b00000);
      chk("wfirst_bresp", bresp, 2'b00);
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      chk("wfirst_bvalid_done", bvalid, 0);
      chk("wfirst_awready_back", awready, 1);
      chk("wfirst_wready_back", wready, 1);

      // W1C: hardware set, clear upper bytes, then clear with coincident set
      hw_set[32 +: 32] = 32'h0000_00FF;
      @(negedge clk);
      hw_set = '0;
      chk("w1c_hwset", reg_out[32 +: 32], 32'hA5A5_00FF);
      axi_write(12'h004, 32'hA5A5_0000, 4'b1100, resp);
      chk("w1c_clear_upper", reg_out[32 +: 32], 32'h0000_00FF);
      hw_set[32] = 1'b1;
      axi_write(12'h004, 32'h0000_000F, 4'b0001, resp);
      hw_set = '0;
      chk("w1c_set_wins", reg_out[32 +: 32], 32'h0000_00F1);
      chk("w1c_bresp", resp, 2'b00);

      // RO register: write has no effect but still pulses
      reg_in[96 +: 32] = 32'hDEAD_BEEF;
      c0 = wr_cnt;
      axi_write(12'h00C, 32'h1234_5678, 4'hF, resp);
      chk("ro_write_no_effect", reg_out[96 +: 32], 32'hDEAD_BEEF);
      chk("ro_write_bresp", resp, 2'b00);
      chk("ro_write_pulse", wr_cnt, c0 + 1);

      // RO read with rready held low for 4 cycles
      c0 = rd_cnt;
      @(negedge clk);
      arvalid = 1'b1; araddr = 12'h00C; rready = 1'b0;
      #1;
      chk("ro_rd_pulse", rd_pulse, 5'b01000);
      @(negedge clk);
      arvalid = 1'b0;
      reg_in[96 +: 32] = 32'h0;
      for (int k = 0; k < 4; k++) begin
         chk("ro_rvalid_hold", rvalid, 1);
         chk("ro_rdata_hold", rdata, 32'hDEAD_BEEF);
         chk("ro_arready_busy", arready, 0);
         @(negedge clk);
      end
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
      chk("ro_rvalid_done", rvalid, 0);
      chk("ro_rd_pulse_once", rd_cnt, c0 + 1);
      chk("ro_rresp", rresp, 2'b00);

      // Plain reads of W1C and RW registers
      axi_read(12'h004, d, resp);
      chk("rd_reg1", d, 32'h0000_00F1);
      chk("rd_reg1_resp", resp, 2'b00);
      axi_read(12'h00A, d, resp);
      chk("rd_reg2_lowbits_ignored", d, 32'h0022_0044);

      // Out-of-range write and read
      exp_all = {RV, 32'h0, 32'h0022_0044, 32'h0000_00F1, RV};
      c0 = wr_cnt;
      axi_write(12'h014, 32'hFFFF_FFFF, 4'hF, resp);
      chk("oor_no_change", reg_out, exp_all);
      chk("oor_bresp", resp, OOR_RESP);
      chk("oor_no_wr_pulse", wr_cnt, c0);
      c0 = rd_cnt;
      axi_read(12'h014, d, resp);
      chk("oor_rdata", d, 32'h0);
      chk("oor_rresp", resp, OOR_RESP);
      chk("oor_no_rd_pulse", rd_cnt, c0);

      // Reset while in the response phase
      @(negedge clk);
      awvalid = 1'b1; awaddr = 12'h000; wvalid = 1'b1; wdata = 32'h1234_5678;
      wstrb = 4'hF; bready = 1'b0;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      @(negedge clk);
      chk("mid_bvalid", bvalid, 1);
      chk("mid_reg0", reg_out[0 +: 32], 32'h1234_5678);
      #2;
      aresetn = 1'b0;
      #1;
      chk("mid_rst_bvalid", bvalid, 0);
      chk("mid_rst_reg0", reg_out[0 +: 32], RV);
      chk("mid_rst_reg1", reg_out[32 +: 32], RV);
      @(negedge clk);
      aresetn = 1'b1;
      @(negedge clk);
      chk("post_rst_awready", awready, 1);
      chk("post_rst_wready", wready, 1);
      axi_write(12'h000, 32'h0000_00FF, 4'b0001, resp);
      chk("post_rst_write", reg_out[0 +: 32], 32'hA5A5_00FF);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
